instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_out_reg.sv | 45 ++++
 rtl/instruction_fetch.sv | 110 +++++++++++
 tb/tb_instruction_fetch.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned ADDR_WIDTH_DEF = 8;
   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned STALL_WIDTH    = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2
   } fetch_state_t;

   // Where the FSM goes once it is free to start another fetch.
   function automatic fetch_state_t resume_state(input logic halt);
      return halt ? IDLE : FETCH;
   endfunction

   function automatic logic [STALL_WIDTH-1:0] sat_inc(input logic [STALL_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Holding register for the fetched word presented to decode.
// A clear (redirect) wins over a load so an in-flight word is dropped.
module fetch_out_reg
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  clear,
   input  logic                  ready,
   input  logic [DATA_WIDTH-1:0] load_instr,
   input  logic [ADDR_WIDTH-1:0] load_pc,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid
);

   logic [DATA_WIDTH-1:0] instr_q;
   logic [ADDR_WIDTH-1:0] instr_pc_q;
   logic                  valid_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         instr_q    <= '0;
         instr_pc_q <= '0;
         valid_q    <= 1'b0;
      end else if (clear) begin
         valid_q <= 1'b0;
      end else if (load) begin
         instr_q    <= load_instr;
         instr_pc_q <= load_pc;
         valid_q    <= 1'b1;
      end else if (valid_q && ready) begin
         valid_q <= 1'b0;
      end
   end

   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch FSM and program-counter control.
// Optional stall counter output enabled by INSTRUCTION_FETCH_STALL_CNT_EN.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [ADDR_WIDTH-1:0]  pc_in,
   output logic                   pc_write,
   output logic [ADDR_WIDTH-1:0]  pc_wdata,
   output logic                   mem_req,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic                   mem_ready,
   input  logic [DATA_WIDTH-1:0]  mem_rdata,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [DATA_WIDTH-1:0]  instr,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   input  logic                   jump_valid,
   input  logic [ADDR_WIDTH-1:0]  jump_target,
   input  logic                   halt
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
   ,
   output logic [STALL_WIDTH-1:0] stall_count
`endif
);

   fetch_state_t state_q, state_d;
   logic         capture;

   // A redirect in the ready cycle discards the returning word.
   assign capture = (state_q == FETCH) && mem_ready && !jump_valid;

   always_comb begin
      state_d = state_q;
      if (jump_valid) begin
         state_d = resume_state(halt);
      end else begin
         case (state_q)
            IDLE:    state_d = resume_state(halt);
            FETCH:   if (mem_ready) state_d = VALID;
            VALID:   if (instr_ready) state_d = resume_state(halt);
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign mem_req  = (state_q == FETCH);
   assign mem_addr = pc_in;

   // The counter self-increments unless loaded; hold it everywhere but the accepted fetch.
   always_comb begin
      pc_write = 1'b0;
      pc_wdata = pc_in;
      if (reset) begin
         if (jump_valid) begin
            pc_write = 1'b1;
            pc_wdata = jump_target;
         end else begin
            pc_write = !((state_q == FETCH) && mem_ready);
         end
      end
   end

   fetch_out_reg #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_reg (
      .clk         (clk),
      .reset       (reset),
      .load        (capture),
      .clear       (jump_valid),
      .ready       (instr_ready),
      .load_instr  (mem_rdata),
      .load_pc     (pc_in),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid)
   );

`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
   logic [STALL_WIDTH-1:0] stall_q;
   logic                   stall_cycle;

   assign stall_cycle = ((state_q == FETCH) && !mem_ready) ||
                        ((state_q == VALID) && !instr_ready);

   always_ff @(posedge clk) begin
      if (!reset) begin
         stall_q <= '0;
      end else if (stall_cycle) begin
         stall_q <= sat_inc(stall_q);
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios then random traffic,
// against a cycle model driven by a bench-side memory image and program counter.
module tb_instruction_fetch;

   logic       clk;
   logic       reset;
   logic [7:0] pc_in;
   logic       pc_write;
   logic [7:0] pc_wdata;
   logic       mem_req;
   logic [7:0] mem_addr;
   logic       mem_ready;
   logic [7:0] mem_rdata;
   logic       instr_valid;
   logic       instr_ready;
   logic [7:0] instr;
   logic [7:0] instr_pc;
   logic       jump_valid;
   logic [7:0] jump_target;
   logic       halt;
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
   logic [15:0] stall_count;
   int          m_stall;
   int          stall0;
`endif

   instruction_fetch #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_in       (pc_in),
      .pc_write    (pc_write),
      .pc_wdata    (pc_wdata),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .jump_valid  (jump_valid),
      .jump_target (jump_target),
      .halt        (halt)
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0] memarr [256];
   logic [7:0] env_pc;
   // Model: 0 = waiting to start, 1 = memory read outstanding, 2 = word on offer.
   int         m_phase;
   logic       m_known;
   logic [7:0] m_word;
   logic [7:0] m_wpc;
   logic       e_pw;
   logic [7:0] e_wd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, advance model and PC at the rising edge.
   task automatic step();
      @(negedge clk);
      e_pw = !reset ? 1'b0 : jump_valid ? 1'b1 : !(m_known && m_phase == 1 && mem_ready);
      e_wd = jump_valid ? jump_target : pc_in;
      chk("pc_write", 32'(pc_write), 32'(e_pw));
      if (e_pw) chk("pc_wdata", 32'(pc_wdata), 32'(e_wd));
      if (m_known) begin
         chk("mem_req", 32'(mem_req), 32'(m_phase == 1));
         if (m_phase == 1) chk("mem_addr", 32'(mem_addr), 32'(pc_in));
         chk("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
         chk("instr", 32'(instr), 32'(m_word));
         chk("instr_pc", 32'(instr_pc), 32'(m_wpc));
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
         chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
      end
      @(posedge clk);
      if (!reset) begin
         m_phase = 0;
         m_word  = 8'h00;
         m_wpc   = 8'h00;
         m_known = 1'b1;
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
         m_stall = 0;
`endif
      end else if (m_known) begin
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
         if (((m_phase == 1 && !mem_ready) || (m_phase == 2 && !instr_ready)) &&
             m_stall < 65535) m_stall++;
`endif
         if (jump_valid) begin
            m_phase = halt ? 0 : 1;
         end else if (m_phase == 0) begin
            m_phase = halt ? 0 : 1;
         end else if (m_phase == 1) begin
            if (mem_ready) begin
               m_word  = memarr[pc_in];
               m_wpc   = pc_in;
               m_phase = 2;
            end
         end else if (instr_ready) begin
            m_phase = halt ? 0 : 1;
         end
      end
      env_pc = e_pw ? e_wd : env_pc + 8'd1;
      #1;
      pc_in     = env_pc;
      mem_rdata = memarr[env_pc];
   endtask

   initial begin
      for (int i = 0; i < 256; i++) memarr[i] = 8'($urandom);
      m_known = 1'b0;
      m_phase = 0;
      m_word  = 8'h00;
      m_wpc   = 8'h00;
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
      m_stall = 0;
`endif
      // The counter runs through the two reset cycles, landing on 0x10.
      env_pc      = 8'h0E;
      pc_in       = env_pc;
      mem_rdata   = memarr[env_pc];
      reset       = 1'b0;
      halt        = 1'b0;
      jump_valid  = 1'b0;
      jump_target = 8'h00;
      mem_ready   = 1'b1;
      instr_ready = 1'b0;
      step();
      step();

      // First fetch after reset release
      reset = 1'b1;
      step();
      chk("first_fetch_addr", 32'(mem_addr), 32'h10);
      chk("first_fetch_req", 32'(mem_req), 32'h1);
      step();
      chk("req33_valid", 32'(instr_valid), 32'h1);
      chk("req33_pc", 32'(instr_pc), 32'h10);
      chk("req33_instr", 32'(instr), 32'(memarr[8'h10]));

      // Downstream stall for five cycles
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
      stall0 = int'(stall_count);
`endif
      repeat (5) step();
      chk("stall_hold_pc", 32'(instr_pc), 32'h10);
`ifdef INSTRUCTION_FETCH_STALL_CNT_EN
      chk("stall_plus5", 32'(int'(stall_count) - stall0), 32'd5);
`endif
      instr_ready = 1'b1;
      step();
      instr_ready = 1'b0;
      mem_ready   = 1'b0;
      step();
      step();
      mem_ready = 1'b1;
      step();

      // Redirect while a word is on offer
      jump_valid  = 1'b1;
      jump_target = 8'h80;
      step();
      jump_valid = 1'b0;
      chk("jump_valid_drop", 32'(instr_valid), 32'h0);
      chk("jump_addr80", 32'(mem_addr), 32'h80);
      mem_ready = 1'b0;
      step();

      // Redirect coincident with memory ready
      jump_valid  = 1'b1;
      jump_target = 8'h40;
      mem_ready   = 1'b1;
      step();
      jump_valid = 1'b0;
      chk("jump_ready_nocap", 32'(instr_valid), 32'h0);
      chk("jump_addr40", 32'(mem_addr), 32'h40);
      step();
      instr_ready = 1'b1;
      step();

      // PC wrap
      jump_valid  = 1'b1;
      jump_target = 8'hFF;
      mem_ready   = 1'b0;
      step();
      jump_valid = 1'b0;
      mem_ready  = 1'b1;
      instr_ready = 1'b0;
      step();
      chk("wrap_instr_pc", 32'(instr_pc), 32'hFF);
      instr_ready = 1'b1;
      step();
      chk("wrap_next_addr", 32'(mem_addr), 32'h00);
      chk("wrap_next_req", 32'(mem_req), 32'h1);

      // Halt during a slow fetch
      instr_ready = 1'b0;
      halt        = 1'b1;
      mem_ready   = 1'b0;
      repeat (3) step();
      mem_ready = 1'b1;
      step();
      chk("halt_delivers", 32'(instr_valid), 32'h1);
      instr_ready = 1'b1;
      step();
      chk("halt_idle_req", 32'(mem_req), 32'h0);
      repeat (2) step();
      halt = 1'b0;
      step();

      // Handshake and redirect in the same cycle
      instr_ready = 1'b0;
      step();
      instr_ready = 1'b1;
      jump_valid  = 1'b1;
      jump_target = 8'h20;
      step();
      jump_valid = 1'b0;
      chk("hs_jump_valid", 32'(instr_valid), 32'h0);
      chk("hs_jump_addr", 32'(mem_addr), 32'h20);

      // Reset while a word is on offer, with competing requests
      instr_ready = 1'b0;
      step();
      reset       = 1'b0;
      jump_valid  = 1'b1;
      instr_ready = 1'b1;
      step();
      chk("rst_valid", 32'(instr_valid), 32'h0);
      chk("rst_instr", 32'(instr), 32'h0);
      chk("rst_pc", 32'(instr_pc), 32'h0);
      chk("rst_req", 32'(mem_req), 32'h0);
      reset      = 1'b1;
      jump_valid = 1'b0;

      // Random traffic
      for (int n = 0; n < 800; n++) begin
         reset       = ($urandom_range(0, 79) != 0);
         halt        = ($urandom_range(0, 7) == 0);
         jump_valid  = ($urandom_range(0, 11) == 0);
         jump_target = 8'($urandom);
         mem_ready   = ($urandom_range(0, 2) != 0);
         instr_ready = ($urandom_range(0, 1) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
